// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo path: run-time modes, TX handshake states
// and the ASCII letter ranges used by the case-swap transform.
package uart_pkg;

  localparam logic [1:0] MODE_ECHO     = 2'b00;
  localparam logic [1:0] MODE_CASESWAP = 2'b01;
  localparam logic [1:0] MODE_HOLD     = 2'b10;
  localparam logic [1:0] MODE_FLUSH    = 2'b11;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_WAIT  = 2'd1,
    TX_START = 2'd2
  } tx_state_e;

  localparam logic [7:0] ASCII_UPPER_LO = 8'h41;
  localparam logic [7:0] ASCII_UPPER_HI = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_LO = 8'h61;
  localparam logic [7:0] ASCII_LOWER_HI = 8'h7A;
  localparam int         ASCII_CASE_BIT = 5;

  // Letters differ from their other-case twin only in bit 5; everything else passes through.
  function automatic logic [7:0] ascii_case_swap(input logic [7:0] c);
    logic [7:0] r;
    r = c;
    if ((c >= ASCII_UPPER_LO && c <= ASCII_UPPER_HI) ||
        (c >= ASCII_LOWER_LO && c <= ASCII_LOWER_HI))
      r[ASCII_CASE_BIT] = ~c[ASCII_CASE_BIT];
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with flush; pointers carry an extra wrap bit so all
// DEPTH slots are usable and full/empty are told apart without a spare entry.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic [AW:0]       level_q;
  logic              do_push;
  logic              do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign level = level_q;

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: queues received words, optionally case-swaps them and feeds
// uart_tx through its start/busy handshake, with drop accounting and occupancy.
module uart_echo_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_ready,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data,
  input  logic [1:0]             mode,
  input  logic                   clr_stat,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);

  tx_state_e         state_q, state_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] xformed;
  logic              drop;

  assign fifo_flush = (mode == MODE_FLUSH);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_ready),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (rx_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Case-swap only makes sense for byte-wide ASCII; other widths pass straight through.
  always_comb begin
    xformed = fifo_head;
    if (DATA_W == 8 && mode == MODE_CASESWAP)
      xformed = DATA_W'(ascii_case_swap(8'(fifo_head)));
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!fifo_empty && (mode == MODE_ECHO || mode == MODE_CASESWAP)) begin
          fifo_pop  = 1'b1;
          tx_data_d = xformed;
          state_d   = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = TX_START;
        end
      end
      TX_START: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = TX_IDLE;
        end
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = TX_IDLE;
      end
    endcase
  end

  // Flushed words are thrown away on purpose and never count as drops.
  assign drop = rx_ready && fifo_full && !fifo_pop && !fifo_flush;

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_stat) begin
      overflow_d = 1'b0;
      drop_cnt_d = drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule
